// File: rtl/svp_pkg.sv
// Shared definitions for the PMP/SVP compare datapath: feeder FSM states and
// the pad sentinel that can never win a compare_tree comparison.
package svp_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } feeder_state_e;

    // Result is truncated by the caller to `width` bits.
    // "min" pads with the most-positive value; "max" with the most-negative.
    function automatic logic [63:0] pad_value(input string kind, input int unsigned width);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        if (kind == "max")
            return msb;
        else
            return msb - 64'd1;
    endfunction

endpackage

// File: rtl/compare_tree_feeder.sv
// Packs a serial stream of signed candidates into 2**DEPTH-lane frames for
// compare_tree, padding short frames and tracking the packet base index.
module compare_tree_feeder
    import svp_pkg::*;
#(
    parameter int unsigned DEPTH      = 7,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 16,
    parameter string       TYPE       = "min"
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic signed [DATA_WIDTH-1:0]        s_val_i,
    input  logic [USER_WIDTH-1:0]               s_user_i,
    input  logic                                s_vld_i,
    input  logic                                s_last_i,
    output logic                                s_rdy_o,
    input  logic                                rdy_i,
    output logic signed [DATA_WIDTH-1:0]        compare_val_o [2**DEPTH],
    output logic [(2**DEPTH)*USER_WIDTH-1:0]    user_val_o,
    output logic                                vld_o,
    output logic                                last_o,
    output logic [DEPTH:0]                      count_o,
    output logic [IDX_WIDTH-1:0]                base_o
);

    localparam int unsigned N = 2**DEPTH;
    localparam logic signed [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(pad_value(TYPE, DATA_WIDTH));
    localparam logic [DEPTH-1:0] LAST_LANE = '1;

    feeder_state_e                  state_q;
    logic signed [DATA_WIDTH-1:0]   val_buf_q  [N];
    logic [USER_WIDTH-1:0]          user_buf_q [N];
    logic [DEPTH-1:0]               lane_q;
    logic [DEPTH:0]                 cnt_q;
    logic                           last_q;
    logic [IDX_WIDTH-1:0]           base_q;

    assign s_rdy_o = (state_q == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            lane_q     <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            base_q     <= '0;
            vld_o      <= 1'b0;
            last_o     <= 1'b0;
            count_o    <= '0;
            base_o     <= '0;
            user_val_o <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                val_buf_q[i]     <= '0;
                user_buf_q[i]    <= '0;
                compare_val_o[i] <= '0;
            end
        end else begin
            vld_o <= 1'b0;
            case (state_q)
                FILL: begin
                    if (s_vld_i) begin
                        val_buf_q[lane_q]  <= s_val_i;
                        user_buf_q[lane_q] <= s_user_i;
                        lane_q             <= lane_q + 1'b1;
                        if (lane_q == LAST_LANE || s_last_i) begin
                            state_q <= HOLD;
                            last_q  <= s_last_i;
                            cnt_q   <= {1'b0, lane_q} + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (rdy_i) begin
                        // Stale lanes beyond the fill count are masked here, so
                        // the buffer never needs clearing between frames.
                        for (int unsigned i = 0; i < N; i++) begin
                            if ((DEPTH+1)'(i) < cnt_q) begin
                                compare_val_o[i]                         <= val_buf_q[i];
                                user_val_o[i*USER_WIDTH +: USER_WIDTH]   <= user_buf_q[i];
                            end else begin
                                compare_val_o[i]                         <= PAD;
                                user_val_o[i*USER_WIDTH +: USER_WIDTH]   <= '0;
                            end
                        end
                        vld_o   <= 1'b1;
                        last_o  <= last_q;
                        count_o <= cnt_q;
                        base_o  <= base_q;
                        base_q  <= last_q ? '0 : base_q + IDX_WIDTH'(cnt_q);
                        lane_q  <= '0;
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_tree_feeder.sv
// Directed and randomized checks of compare_tree_feeder against a packet-level
// frame model (N=4, 16-bit data, plus a second instance in "max" mode).
module tb_compare_tree_feeder;

  localparam int N = 4;

  typedef struct {
    logic [63:0] vals;
    logic [3:0]  users;
    logic [2:0]  cnt;
    logic [15:0] base;
    logic        last;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] s_val_i = '0;
  logic [0:0]         s_user_i = '0;
  logic               s_vld_i = 1'b0;
  logic               s_last_i = 1'b0;
  logic               s_rdy_o;
  logic               rdy_i = 1'b1;
  logic signed [15:0] compare_val_o [4];
  logic [3:0]         user_val_o;
  logic               vld_o;
  logic               last_o;
  logic [2:0]         count_o;
  logic [15:0]        base_o;

  logic signed [15:0] m_val_i = '0;
  logic [0:0]         m_user_i = '0;
  logic               m_vld_i = 1'b0;
  logic               m_last_i = 1'b0;
  logic               m_s_rdy_o;
  logic               m_rdy_i = 1'b1;
  logic signed [15:0] m_compare_val_o [4];
  logic [3:0]         m_user_val_o;
  logic               m_vld_o;
  logic               m_last_o;
  logic [2:0]         m_count_o;
  logic [15:0]        m_base_o;

  compare_tree_feeder #(.DEPTH(2), .USER_WIDTH(1), .DATA_WIDTH(16), .IDX_WIDTH(16), .TYPE("min")) dut (
    .clk(clk), .rst_n(rst_n),
    .s_val_i(s_val_i), .s_user_i(s_user_i), .s_vld_i(s_vld_i), .s_last_i(s_last_i),
    .s_rdy_o(s_rdy_o), .rdy_i(rdy_i),
    .compare_val_o(compare_val_o), .user_val_o(user_val_o), .vld_o(vld_o),
    .last_o(last_o), .count_o(count_o), .base_o(base_o)
  );

  compare_tree_feeder #(.DEPTH(2), .USER_WIDTH(1), .DATA_WIDTH(16), .IDX_WIDTH(16), .TYPE("max")) dut_max (
    .clk(clk), .rst_n(rst_n),
    .s_val_i(m_val_i), .s_user_i(m_user_i), .s_vld_i(m_vld_i), .s_last_i(m_last_i),
    .s_rdy_o(m_s_rdy_o), .rdy_i(m_rdy_i),
    .compare_val_o(m_compare_val_o), .user_val_o(m_user_val_o), .vld_o(m_vld_o),
    .last_o(m_last_o), .count_o(m_count_o), .base_o(m_base_o)
  );

  int checks = 0;
  int failures = 0;
  frame_t got_q[$];
  frame_t exp_q[$];
  int pv[$];
  int pu[$];
  bit rand_mode = 1'b0;

  task automatic report(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (vld_o === 1'b1) begin
      frame_t f;
      f.vals  = {compare_val_o[3], compare_val_o[2], compare_val_o[1], compare_val_o[0]};
      f.users = user_val_o;
      f.cnt   = count_o;
      f.base  = base_o;
      f.last  = last_o;
      got_q.push_back(f);
    end
  end

  // Reference: split the packet into N-sized chunks, pad the tail chunk.
  task automatic model_packet();
    int n = pv.size();
    int base = 0;
    for (int s = 0; s < n; s += N) begin
      frame_t f;
      int c = (n - s < N) ? (n - s) : N;
      f.cnt  = 3'(c);
      f.base = 16'(base);
      f.last = (s + c == n);
      f.vals = '0;
      f.users = '0;
      for (int i = 0; i < N; i++) begin
        if (i < c) begin
          f.vals[i*16 +: 16] = 16'(pv[s+i]);
          f.users[i]         = 1'(pu[s+i]);
        end else begin
          f.vals[i*16 +: 16] = 16'h7FFF;
        end
      end
      exp_q.push_back(f);
      base += c;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input int v, input int u, input bit last);
    int guard = 0;
    if (rand_mode && $urandom_range(0, 3) == 0) begin
      s_vld_i = 1'b0;
      @(negedge clk);
    end
    s_val_i  = 16'(v);
    s_user_i = 1'(u);
    s_last_i = last;
    s_vld_i  = 1'b1;
    if (rand_mode) rdy_i = ($urandom_range(0, 3) != 0);
    while (s_rdy_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      if (rand_mode) rdy_i = ($urandom_range(0, 3) != 0);
      guard++;
    end
    if (guard >= 50) report("beat_accept_timeout", guard === 0, guard, 0);
    @(negedge clk);
    s_vld_i  = 1'b0;
    s_last_i = 1'b0;
  endtask

  task automatic send_packet();
    model_packet();
    for (int i = 0; i < pv.size(); i++)
      send_beat(pv[i], pu[i], i == pv.size() - 1);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    rdy_i = 1'b1;
    while (got_q.size() < exp_q.size() && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    report({tag, "_frames"}, got_q.size() === exp_q.size(), got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      frame_t g = got_q.pop_front();
      frame_t e = exp_q.pop_front();
      report({tag, "_vals"}, g.vals === e.vals, g.vals, e.vals);
      report({tag, "_users"}, g.users === e.users, g.users, e.users);
      report({tag, "_count"}, g.cnt === e.cnt, g.cnt, e.cnt);
      report({tag, "_base"}, g.base === e.base, g.base, e.base);
      report({tag, "_last"}, g.last === e.last, g.last, e.last);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] vals;
    #12;
    report("rst_vld", vld_o === 1'b0, vld_o, 1'b0);
    report("rst_count", count_o === 3'd0, count_o, 3'd0);
    vals = {compare_val_o[3], compare_val_o[2], compare_val_o[1], compare_val_o[0]};
    report("rst_vals", vals === 64'd0, vals, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    report("rst_srdy", s_rdy_o === 1'b1, s_rdy_o, 1'b1);

    pv = {5, -3, 7, 2}; pu = {1, 0, 1, 0};
    send_packet();
    report("exact_vld_early", vld_o === 1'b0, vld_o, 1'b0);
    report("exact_hold_srdy", s_rdy_o === 1'b0, s_rdy_o, 1'b0);
    @(negedge clk);
    report("exact_vld_latency", vld_o === 1'b1, vld_o, 1'b1);
    @(negedge clk);
    report("exact_vld_single", vld_o === 1'b0, vld_o, 1'b0);
    drain("exact");

    pv = {-8, 4}; pu = {1, 1};
    send_packet();
    drain("short");

    pv = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10}; pu = {0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    send_packet();
    pv = {11, 12, 13}; pu = {1, 1, 1};
    send_packet();
    drain("long");

    rdy_i = 1'b0;
    pv = {100, -200, 300, -400}; pu = {0, 0, 1, 1};
    send_packet();
    for (int i = 0; i < 5; i++) begin
      report("bp_srdy", s_rdy_o === 1'b0, s_rdy_o, 1'b0);
      report("bp_vld", vld_o === 1'b0, vld_o, 1'b0);
      @(negedge clk);
    end
    report("bp_no_frame", got_q.size() === 0, got_q.size(), 0);
    rdy_i = 1'b1;
    @(negedge clk);
    report("bp_release_vld", vld_o === 1'b1, vld_o, 1'b1);
    drain("bp");

    m_val_i = -16'sd100; m_user_i = 1'b1; m_last_i = 1'b1; m_vld_i = 1'b1;
    @(negedge clk);
    m_vld_i = 1'b0; m_last_i = 1'b0;
    @(negedge clk);
    report("max_vld", m_vld_o === 1'b1, m_vld_o, 1'b1);
    vals = {m_compare_val_o[3], m_compare_val_o[2], m_compare_val_o[1], m_compare_val_o[0]};
    report("max_vals", vals === 64'h8000_8000_8000_FF9C, vals, 64'h8000_8000_8000_FF9C);
    report("max_users", m_user_val_o === 4'b0001, m_user_val_o, 4'b0001);
    report("max_count", m_count_o === 3'd1, m_count_o, 3'd1);
    report("max_last", m_last_o === 1'b1, m_last_o, 1'b1);

    send_beat(-1, 1, 1'b0);
    send_beat(-2, 1, 1'b0);
    send_beat(-3, 1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    report("arst_vld", vld_o === 1'b0, vld_o, 1'b0);
    report("arst_last", last_o === 1'b0, last_o, 1'b0);
    report("arst_count", count_o === 3'd0, count_o, 3'd0);
    report("arst_base", base_o === 16'd0, base_o, 16'd0);
    vals = {compare_val_o[3], compare_val_o[2], compare_val_o[1], compare_val_o[0]};
    report("arst_vals", vals === 64'd0, vals, 64'd0);
    report("arst_users", user_val_o === 4'd0, user_val_o, 4'd0);
    report("arst_srdy", s_rdy_o === 1'b1, s_rdy_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    pv = {9, 8, -7, 6}; pu = {0, 1, 0, 0};
    send_packet();
    drain("post_rst");

    rand_mode = 1'b1;
    for (int p = 0; p < 10; p++) begin
      int n = $urandom_range(1, 10);
      pv.delete(); pu.delete();
      for (int i = 0; i < n; i++) begin
        pv.push_back(int'($urandom_range(0, 65535)) - 32768);
        pu.push_back(int'($urandom_range(0, 1)));
      end
      send_packet();
    end
    rand_mode = 1'b0;
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
